// File: rtl/ifu_fetch.sv
// Instruction fetch unit: fetches one word at a time from instruction memory,
// holds it for the decoder, waits for execute to retire it, then moves the PC
// to the committed next PC. Faults and EBREAK park the unit until reset.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] pc,
  input  logic        commit_valid,
  input  logic [31:0] commit_npc,
  input  logic        commit_halt,
  output logic        halted,
  output logic [1:0]  fault,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_EXEC,
    S_STOP
  } state_t;

  localparam logic [1:0] FAULT_NONE  = 2'b00;
  localparam logic [1:0] FAULT_FETCH = 2'b01;
  localparam logic [1:0] FAULT_ALIGN = 2'b10;

  state_t state;
  state_t state_nxt;

  // Qualified events; responses and commits outside their own state are ignored.
  logic rsp_ok;
  logic rsp_err;
  logic commit;
  logic npc_misaligned;

  assign rsp_ok         = (state == S_WAIT) && imem_rvalid && !imem_err;
  assign rsp_err        = (state == S_WAIT) && imem_rvalid &&  imem_err;
  assign commit         = (state == S_EXEC) && commit_valid;
  assign npc_misaligned = (commit_npc[1:0] != 2'b00);

  // The reset state is REQ, so the request is masked while rst_n is low.
  assign imem_req   = (state == S_REQ) && rst_n;
  assign imem_addr  = {pc[31:2], 2'b00};
  assign inst_valid = (state == S_HOLD);
  assign halted     = (state == S_STOP);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_REQ;
    else        state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:  if (imem_ready)  state_nxt = S_WAIT;
      S_WAIT: if (imem_rvalid) state_nxt = imem_err ? S_STOP : S_HOLD;
      S_HOLD: if (inst_ready)  state_nxt = S_EXEC;
      S_EXEC: begin
        if (commit_valid) begin
          // Halt wins over a misaligned target in the same commit.
          if (commit_halt)         state_nxt = S_STOP;
          else if (npc_misaligned) state_nxt = S_STOP;
          else                     state_nxt = S_REQ;
        end
      end
      S_STOP:  state_nxt = S_STOP;
      default: state_nxt = S_REQ;
    endcase
  end

  // Instruction latch, PC, sticky fault cause and retirement counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst    <= '0;
      pc      <= {RESET_PC[31:2], 2'b00};
      fault   <= FAULT_NONE;
      retired <= '0;
    end else begin
      if (rsp_ok)  inst  <= imem_rdata;
      if (rsp_err) fault <= FAULT_FETCH;
      if (commit) begin
        retired <= retired + 32'd1;
        if (!commit_halt) begin
          if (npc_misaligned) fault <= FAULT_ALIGN;
          else                pc    <= commit_npc;
        end
      end
    end
  end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port imem_req, output, 1, fetch request valid.
REQ-005 SHALL have port imem_addr, output, 32, word-aligned fetch address.
REQ-006 SHALL have port imem_ready, input, 1, request accepted when high with imem_req.
REQ-007 SHALL have port imem_rvalid, input, 1, fetch response valid.
REQ-008 SHALL have port imem_rdata, input, 32, fetched instruction word.
REQ-009 SHALL have port imem_err, input, 1, access fault; qualified by imem_rvalid.
REQ-010 SHALL have port inst, output, 32, instruction word presented to the decoder.
REQ-011 SHALL have port inst_valid, output, 1, inst holds a fetched word.
REQ-012 SHALL have port inst_ready, input, 1, decoder consumes inst when high with inst_valid.
REQ-013 SHALL have port pc, output, 32, address of the current instruction.
REQ-014 SHALL have port commit_valid, input, 1, current instruction retired.
REQ-015 SHALL have port commit_npc, input, 32, next PC chosen by execute (pc+4, branch/JAL target, or JALR target).
REQ-016 SHALL have port commit_halt, input, 1, retiring instruction is EBREAK.
REQ-017 SHALL have port halted, output, 1, sticky stop indicator.
REQ-018 SHALL have port fault, output, 2, sticky cause: 00 none, 01 fetch access fault, 10 misaligned next PC.
REQ-019 SHALL have port retired, output, 32, count of committed instructions.

Function
REQ-020 SHALL implement states REQ, WAIT, HOLD, EXEC, STOP.
REQ-021 REQ: imem_req=1, imem_addr=pc; on imem_ready go to WAIT; otherwise hold imem_req and imem_addr stable.
REQ-022 WAIT: imem_req=0; on imem_rvalid with imem_err=0, capture imem_rdata into inst and go to HOLD; on imem_rvalid with imem_err=1, set fault=01 and go to STOP.
REQ-023 SHALL ignore imem_rvalid in any state other than WAIT; a response in the same cycle as acceptance is not accepted.
REQ-024 HOLD: inst_valid=1, inst stable; on inst_ready go to EXEC.
REQ-025 EXEC: inst_valid=0, inst and pc unchanged; wait indefinitely for commit_valid.
REQ-026 On commit_valid in EXEC: retired increments by 1 (wraps 32'hFFFF_FFFF to 0); if commit_halt=1, go to STOP with pc unchanged; else if commit_npc[1:0]!=0, set fault=10 and go to STOP; else set pc=commit_npc and go to REQ.
REQ-027 commit_halt SHALL take priority over misalignment when both occur in the same commit.
REQ-028 commit_valid outside EXEC SHALL be ignored: no count, no pc change.
REQ-029 STOP: halted=1, imem_req=0, inst_valid=0; the block remains in STOP until reset.
REQ-030 Best-case latency from entering REQ to inst_valid=1 SHALL be 2 cycles with imem_ready=1 and a 1-cycle response.
REQ-031 imem_addr[1:0] SHALL always be 00.

Reset
REQ-032 rst_n=0 SHALL immediately force state=REQ, pc=RESET_PC, inst=0, inst_valid=0, halted=0, fault=00, retired=0; imem_req is 0 while rst_n=0 and asserts in the first cycle after release.
REQ-033 Reset asserted mid-fetch SHALL abandon the outstanding request. The memory SHALL share rst_n, so no stale response follows.

Verification
REQ-034 Reset release, imem_ready=1, rdata=32'h0000_0513 one cycle later -> imem_addr=8000_0000; inst_valid=1 two cycles after first req; inst=0000_0513.
REQ-035 imem_ready low 3 cycles -> imem_req and imem_addr=8000_0000 held stable for 4 cycles; one acceptance only.
REQ-036 Commit with commit_npc=8000_0010 -> retired=1; next imem_addr=8000_0010.
REQ-037 Commit with commit_halt=1 and commit_npc=8000_0002 -> halted=1, fault=00, no further imem_req.
REQ-038 Commit with commit_npc=8000_0006 -> fault=10, halted=1; response with imem_err=1 -> fault=01, halted=1.
REQ-039 Stray imem_rvalid in HOLD or EXEC, and commit_valid in HOLD -> inst, pc and retired unchanged.
